btn_event_scheduler: RTL and testbench

Time-shared debounce scheduler for a bank of mechanical buttons. A single prescaler and a single scan FSM sequence every channel through per-button debounce and hold counters. Each debounced transition becomes a PRESS, RELEASE or LONG event, queued in a small FIFO with a valid/ready handshake. The block sits between the raw board button pins and the user-interface logic, and replaces per-button free-running debouncers.

---
 rtl/btn_evt_pkg.sv | 24 ++
 rtl/btn_event_scheduler_evt_fifo.sv | 48 ++++
 rtl/btn_event_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_btn_event_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types for the button event scheduler: event kinds, scan states
// and the event record carried through the FIFO.
package btn_evt_pkg;

  // Wide enough for the largest supported bank (16 channels)
  localparam int BTN_W = 4;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } evt_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [BTN_W-1:0] btn;
    evt_type_e        kind;
  } evt_t;

endpackage

// File: rtl/btn_event_scheduler_evt_fifo.sv
// First-word-fall-through event FIFO. A push while full is taken only when
// the head is popped in the same cycle, so the freed slot absorbs it.
module evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  evt_t push_data,
  output logic full,
  input  logic pop,
  output logic empty,
  output evt_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  evt_t        mem [DEPTH];
  logic        rd_en;
  logic        wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer bookkeeping; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is plain data and needs no reset; empty slots are never exposed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// Time-shared debounce scheduler: one prescaler and one scan FSM visit each
// button channel once per sample tick, debouncing it and timing long holds.
// Accepted transitions and long holds are queued as events in a small FIFO.
module btn_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTNS     = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 8,
  parameter int LONG_TICKS   = 64,
  parameter int FIFO_DEPTH   = 4,
  localparam int IDX_W       = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_btn,
  output logic [1:0]          evt_type,
  output logic                evt_overflow,
  input  logic                clear_overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int HW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;

  logic [NUM_BTNS-1:0] sync_p0;
  logic [NUM_BTNS-1:0] sync_p1;

  logic [PW-1:0]       presc;
  logic                tick;
  scan_state_e         state;
  logic [IDX_W-1:0]    idx;

  logic [NUM_BTNS-1:0] stable;
  logic [NUM_BTNS-1:0] long_fired;
  logic [DW-1:0]       deb_cnt  [NUM_BTNS];
  logic [HW-1:0]       hold_cnt [NUM_BTNS];

  logic                visit;
  logic                cur_sync;
  logic                cur_stable;
  logic                accept;
  logic                long_hit;
  logic                push_req;
  evt_t                push_data;

  logic                fifo_full;
  logic                fifo_empty;
  logic                pop_ok;
  logic                drop;
  evt_t                head;

  // Two-stage synchronizer on the raw pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  assign tick = (presc == PW'(TICK_DIV-1));

  // Free-running sample prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Scan FSM: each tick starts one pass over all channels, one per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (idx == IDX_W'(NUM_BTNS-1)) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Decide what the current visit produces
  always_comb begin
    visit      = (state == SCAN);
    cur_sync   = sync_p1[idx];
    cur_stable = stable[idx];
    accept     = visit && (cur_sync != cur_stable) &&
                 (deb_cnt[idx] == DW'(STABLE_TICKS-1));
    long_hit   = visit && (cur_sync == cur_stable) && cur_stable &&
                 !long_fired[idx] && (hold_cnt[idx] == HW'(LONG_TICKS-1));
    push_req   = accept || long_hit;
    push_data.btn  = BTN_W'(idx);
    push_data.kind = long_hit ? EVT_LONG : (cur_sync ? EVT_PRESS : EVT_RELEASE);
  end

  // Per-channel debounce and hold counters, updated only on that channel's visit
  always_ff @(posedge clk) begin
    if (reset) begin
      stable     <= '0;
      long_fired <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
    end else if (visit) begin
      if (cur_sync != cur_stable) begin
        if (accept) begin
          stable[idx]     <= cur_sync;
          deb_cnt[idx]    <= '0;
          hold_cnt[idx]   <= '0;
          long_fired[idx] <= 1'b0;
        end else begin
          deb_cnt[idx] <= deb_cnt[idx] + DW'(1);
        end
      end else begin
        // Any visit agreeing with the accepted level restarts the debounce
        deb_cnt[idx] <= '0;
        if (cur_stable && !long_fired[idx]) begin
          if (long_hit) begin
            long_fired[idx] <= 1'b1;
          end else begin
            hold_cnt[idx] <= hold_cnt[idx] + HW'(1);
          end
        end
      end
    end
  end

  assign pop_ok = !fifo_empty && evt_ready;
  assign drop   = push_req && fifo_full && !pop_ok;

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_overflow <= 1'b0;
    end else if (drop) begin
      evt_overflow <= 1'b1;
    end else if (clear_overflow) begin
      evt_overflow <= 1'b0;
    end
  end

  evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (evt_ready),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign btn_state = stable;
  assign evt_valid = !fifo_empty;
  assign evt_btn   = evt_valid ? IDX_W'(head.btn) : '0;
  assign evt_type  = evt_valid ? head.kind : 2'd0;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Bench for btn_event_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the scheduler.
module tb_btn_event_scheduler;

  localparam int NB = 4;
  localparam int TD = 8;
  localparam int ST = 3;
  localparam int LT = 4;
  localparam int FD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_btn;
  logic [1:0] evt_type;
  logic       evt_overflow;
  logic       clear_overflow = 1'b0;

  btn_event_scheduler #(
    .NUM_BTNS     (NB),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .LONG_TICKS   (LT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_in         (btn_in),
    .btn_state      (btn_state),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_btn        (evt_btn),
    .evt_type       (evt_type),
    .evt_overflow   (evt_overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: cycles since reset decide which channel is sampled,
  // events are kept in a queue encoded as btn*4+type.
  int         m_t = 0;
  logic [3:0] m_s1 = '0;
  logic [3:0] m_s2 = '0;
  logic [3:0] m_stab = '0;
  int         m_deb [NB];
  int         m_hold [NB];
  bit         m_lf [NB];
  int         m_q [$];
  bit         m_ovf = 0;

  int log_btn [$];
  int log_typ [$];

  task automatic model_edge(input logic [3:0] b, input logic r, input logic rdy, input logic clr);
    int ch;
    bit have;
    int et;
    if (r) begin
      m_t = 0;
      m_s1 = '0;
      m_s2 = '0;
      m_stab = '0;
      for (int i = 0; i < NB; i++) begin
        m_deb[i] = 0;
        m_hold[i] = 0;
        m_lf[i] = 0;
      end
      m_q.delete();
      m_ovf = 0;
    end else begin
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      ch = -1;
      have = 0;
      et = 0;
      if (m_t >= TD && (m_t % TD) < NB) ch = m_t % TD;
      if (ch >= 0) begin
        if (m_s2[ch] != m_stab[ch]) begin
          if (m_deb[ch] == ST - 1) begin
            m_stab[ch] = ~m_stab[ch];
            m_deb[ch] = 0;
            m_hold[ch] = 0;
            m_lf[ch] = 0;
            have = 1;
            et = m_stab[ch] ? 0 : 1;
          end else begin
            m_deb[ch]++;
          end
        end else begin
          m_deb[ch] = 0;
          if (m_stab[ch] && !m_lf[ch]) begin
            if (m_hold[ch] == LT - 1) begin
              have = 1;
              et = 2;
              m_lf[ch] = 1;
            end else begin
              m_hold[ch]++;
            end
          end
        end
      end
      if (clr) m_ovf = 0;
      if (have) begin
        if (m_q.size() < FD) m_q.push_back(ch * 4 + et);
        else m_ovf = 1;
      end
      m_s2 = m_s1;
      m_s1 = b;
      m_t++;
    end
  endtask

  task automatic compare_outputs();
    int hb;
    int ht;
    hb = (m_q.size() > 0) ? m_q[0] / 4 : 0;
    ht = (m_q.size() > 0) ? m_q[0] % 4 : 0;
    check("btn_state", btn_state, m_stab);
    check("evt_valid", evt_valid, m_q.size() > 0);
    check("evt_btn", evt_btn, hb);
    check("evt_type", evt_type, ht);
    check("evt_overflow", evt_overflow, m_ovf);
  endtask

  task automatic cycle(input logic [3:0] b, input logic r, input logic rdy, input logic clr);
    btn_in = b;
    reset = r;
    evt_ready = rdy;
    clear_overflow = clr;
    if (!r && evt_valid === 1'b1 && rdy) begin
      log_btn.push_back(int'(evt_btn));
      log_typ.push_back(int'(evt_type));
    end
    @(posedge clk);
    model_edge(b, r, rdy, clr);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic [3:0] b, input logic rdy, input logic clr);
    for (int i = 0; i < n; i++) cycle(b, 1'b0, rdy, clr);
  endtask

  int exp_typ [3] = '{0, 2, 1};

  initial begin
    int n;
    int rate;
    logic [3:0] b;
    logic rdy;
    logic clr;
    logic r;

    // Reset with all pins pressed
    for (int i = 0; i < 5; i++) cycle(4'hF, 1'b1, 1'b0, 1'b0);
    check("rst_state", btn_state, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_btn", evt_btn, 0);
    check("rst_type", evt_type, 0);
    check("rst_ovf", evt_overflow, 0);
    n = 0;
    while (evt_valid !== 1'b1 && n < 100) begin
      cycle(4'hF, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("first_evt_seen", evt_valid, 1);
    check("first_evt_not_early", n >= 3 * TD, 1);
    idle(120, 4'h0, 1'b1, 1'b0);
    cycle(4'h0, 1'b0, 1'b1, 1'b1);

    // Clean press on channel 2
    n = 0;
    while (btn_state[2] !== 1'b1 && n < 80) begin
      cycle(4'b0100, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("press_state", btn_state, 4'b0100);
    check("press_valid", evt_valid, 1);
    check("press_btn", evt_btn, 2);
    check("press_type", evt_type, 0);
    cycle(4'b0100, 1'b0, 1'b1, 1'b0);
    check("press_single", evt_valid, 0);
    idle(80, 4'h0, 1'b1, 1'b0);

    // Bounce on channel 1: level toggles every two ticks
    log_btn.delete();
    log_typ.delete();
    for (int k = 0; k < 8; k++) idle(16, (k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
    idle(40, 4'h0, 1'b1, 1'b0);
    check("bounce_state", btn_state[1], 0);
    check("bounce_events", log_btn.size(), 0);

    // Long press then release on channel 0
    log_btn.delete();
    log_typ.delete();
    idle(12 * TD, 4'b0001, 1'b1, 1'b0);
    idle(8 * TD, 4'b0000, 1'b1, 1'b0);
    check("long_count", log_btn.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("long_order_type", (i < log_typ.size()) ? log_typ[i] : 15, exp_typ[i]);
      check("long_order_btn", (i < log_btn.size()) ? log_btn[i] : 15, 0);
    end

    // Overflow: three presses into a two-entry FIFO with no consumer
    cycle(4'h0, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (btn_state !== 4'b1011 && n < 80) begin
      cycle(4'b1011, 1'b0, 1'b0, 1'b0);
      n++;
    end
    idle(TD, 4'b1011, 1'b0, 1'b0);
    check("ovf_flag", evt_overflow, 1);
    check("ovf_state", btn_state, 4'b1011);
    check("ovf_head_btn", evt_btn, 0);
    check("ovf_head_type", evt_type, 0);
    cycle(4'b1011, 1'b0, 1'b0, 1'b1);
    check("ovf_clear", evt_overflow, 0);
    log_btn.delete();
    log_typ.delete();
    idle(4, 4'b1011, 1'b1, 1'b0);
    check("drain_pops", log_btn.size(), 2);
    check("drain_valid", evt_valid, 0);
    check("drain_first", (log_btn.size() > 0) ? log_btn[0] : 15, 0);
    check("drain_second", (log_btn.size() > 1) ? log_btn[1] : 15, 1);
    idle(80, 4'h0, 1'b1, 1'b0);
    cycle(4'h0, 1'b0, 1'b1, 1'b1);

    // Reset during a scan with one event queued
    n = 0;
    while (evt_valid !== 1'b1 && n < 80) begin
      cycle(4'b0100, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("mr_queued", evt_valid, 1);
    n = 0;
    while (!(m_t >= TD && (m_t % TD) == 1) && n < 20) begin
      cycle(4'b0100, 1'b0, 1'b0, 1'b0);
      n++;
    end
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    check("mr_valid", evt_valid, 0);
    check("mr_state", btn_state, 0);
    n = 0;
    while (evt_valid !== 1'b1 && n < 80) begin
      cycle(4'b0100, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("mr_restart_valid", evt_valid, 1);
    check("mr_restart_btn", evt_btn, 2);
    check("mr_restart_not_early", n >= 3 * TD, 1);
    idle(80, 4'h0, 1'b1, 1'b0);

    // Randomized traffic at several toggle rates
    b = '0;
    rate = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 8;
          1: rate = 30;
          default: rate = 120;
        endcase
      end
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, rate - 1) == 0) b[k] = ~b[k];
      end
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      r   = ($urandom_range(0, 799) == 0);
      cycle(b, r, rdy, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
